// File: rtl/mcy_trace_pkg.sv
// Shared types for the MCY PC trace checker.
//   pc_t          - 32-bit program counter value
//   fail_cause_e  - reason the checker entered FAIL
//   chk_state_e   - checker FSM state encoding
package mcy_trace_pkg;

   typedef logic [31:0] pc_t;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_MISMATCH = 2'd1,
      CAUSE_TIMEOUT  = 2'd2,
      CAUSE_OVERFLOW = 2'd3
   } fail_cause_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAIL = 2'd2
   } chk_state_e;

endpackage

// File: rtl/mcy_trace_fifo.sv
// Synchronous PC FIFO, DEPTH entries of pc_t.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clr_i          synchronous flush (pointers to zero)
//   push_i, din_i  write strobe and data
//   pop_i          read strobe; head_o is valid while empty_o is low
//   full_o/empty_o occupancy flags
//   overflow_o     pulse: push while full with no same-cycle pop (write dropped)
module mcy_trace_fifo
   import mcy_trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic        pop_i,
   input  logic [31:0] din_i,
   output logic [31:0] head_o,
   output logic        full_o,
   output logic        empty_o,
   output logic        overflow_o
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB on each pointer distinguishes full from empty when indices match.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   pc_t         mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty_o    = (wr_ptr == rd_ptr);
   assign full_o     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop     = pop_i && !empty_o;
   // When full, a same-cycle pop frees the head slot, which is exactly the slot written.
   assign do_push    = push_i && (!full_o || do_pop);
   assign overflow_o = push_i && full_o && !do_pop;
   assign head_o     = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/mcy_pc_trace_checker.sv
// Compares the mutant core's ID-stage PC stream against a golden core's stream
// in order and flags the first divergence, stall or buffer overflow.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   enable_i, mutsel_i            start request and mutation index (sampled in IDLE)
//   mut_valid_i/mut_pc_i          mutant PC strobe and value
//   gold_valid_i/gold_pc_i        golden PC strobe and value
//   busy_o, fail_o, cause_o       status (registered)
//   fail_mutsel_o                 mutation index latched at start
//   fail_idx_o, fail_*_pc_o       diagnostic capture at failure
//   cmp_count_o                   successful compares since start (saturating)
//
// state | meaning
// IDLE  | waiting for enable_i; FIFOs held empty, strobes ignored
// RUN   | buffering and comparing both PC streams
// FAIL  | terminal, outputs frozen until rst_i
module mcy_pc_trace_checker
   import mcy_trace_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic [7:0]       mutsel_i,
   input  logic             mut_valid_i,
   input  logic [31:0]      mut_pc_i,
   input  logic             gold_valid_i,
   input  logic [31:0]      gold_pc_i,
   output logic             busy_o,
   output logic             fail_o,
   output logic [1:0]       cause_o,
   output logic [7:0]       fail_mutsel_o,
   output logic [CNT_W-1:0] fail_idx_o,
   output logic [31:0]      fail_mut_pc_o,
   output logic [31:0]      fail_gold_pc_o,
   output logic [CNT_W-1:0] cmp_count_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   chk_state_e  state;
   fail_cause_e cause;
   logic [TW-1:0] timeout_cnt;

   logic run;
   logic fifo_clr;
   logic mut_full, mut_empty, mut_ovf;
   logic gold_full, gold_empty, gold_ovf;
   pc_t  mut_head, gold_head;
   logic cmp, mismatch, overflow, one_pending, timeout_hit;

   assign run      = (state == ST_RUN);
   assign fifo_clr = (state == ST_IDLE);

   mcy_trace_fifo #(.DEPTH(DEPTH)) u_mut_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (fifo_clr),
      .push_i     (run && mut_valid_i),
      .pop_i      (cmp),
      .din_i      (mut_pc_i),
      .head_o     (mut_head),
      .full_o     (mut_full),
      .empty_o    (mut_empty),
      .overflow_o (mut_ovf)
   );

   mcy_trace_fifo #(.DEPTH(DEPTH)) u_gold_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (fifo_clr),
      .push_i     (run && gold_valid_i),
      .pop_i      (cmp),
      .din_i      (gold_pc_i),
      .head_o     (gold_head),
      .full_o     (gold_full),
      .empty_o    (gold_empty),
      .overflow_o (gold_ovf)
   );

   assign cmp         = run && !mut_empty && !gold_empty;
   assign mismatch    = cmp && (mut_head != gold_head);
   assign overflow    = run && (mut_ovf || gold_ovf);
   assign one_pending = run && (mut_empty != gold_empty);
   // The counter would reach TIMEOUT on this edge.
   assign timeout_hit = one_pending && (timeout_cnt == TO_LAST);
   assign cause_o     = cause;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         cause          <= CAUSE_NONE;
         timeout_cnt    <= '0;
         busy_o         <= 1'b0;
         fail_o         <= 1'b0;
         fail_mutsel_o  <= '0;
         fail_idx_o     <= '0;
         fail_mut_pc_o  <= '0;
         fail_gold_pc_o <= '0;
         cmp_count_o    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable_i) begin
                  state          <= ST_RUN;
                  busy_o         <= 1'b1;
                  fail_o         <= 1'b0;
                  cause          <= CAUSE_NONE;
                  timeout_cnt    <= '0;
                  fail_mutsel_o  <= mutsel_i;
                  fail_idx_o     <= '0;
                  fail_mut_pc_o  <= '0;
                  fail_gold_pc_o <= '0;
                  cmp_count_o    <= '0;
               end
            end
            ST_RUN: begin
               if (one_pending) timeout_cnt <= timeout_cnt + 1'b1;
               else             timeout_cnt <= '0;

               if (mismatch) begin
                  state          <= ST_FAIL;
                  busy_o         <= 1'b0;
                  fail_o         <= 1'b1;
                  cause          <= CAUSE_MISMATCH;
                  fail_idx_o     <= cmp_count_o;
                  fail_mut_pc_o  <= mut_head;
                  fail_gold_pc_o <= gold_head;
               end else if (overflow) begin
                  state      <= ST_FAIL;
                  busy_o     <= 1'b0;
                  fail_o     <= 1'b1;
                  cause      <= CAUSE_OVERFLOW;
                  fail_idx_o <= cmp_count_o;
               end else if (timeout_hit) begin
                  state      <= ST_FAIL;
                  busy_o     <= 1'b0;
                  fail_o     <= 1'b1;
                  cause      <= CAUSE_TIMEOUT;
                  fail_idx_o <= cmp_count_o;
               end else if (cmp && (cmp_count_o != '1)) begin
                  cmp_count_o <= cmp_count_o + 1'b1;
               end
            end
            ST_FAIL: begin
               state <= ST_FAIL;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
